// File: rtl/booth_divider_seq_if.sv
// Handshake and operand/result bundle for the sequential signed divider.
// The master drives the request; the slave (the divider) returns results.
interface booth_divider_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/booth_divider_seq.sv
// Sequential signed divider: one restoring step per clock on operand magnitudes,
// followed by sign correction. Truncates toward zero like Verilog / and %.
module booth_divider_seq #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  booth_divider_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mag_d, mag_v, quotient_r, remainder_r;
  logic [WIDTH:0]   prem;
  logic [WIDTH+1:0] shifted, trial;
  logic             sign_q, sign_r, done_r, dbz_r;
  logic             accept, zero_div, last_iter;

  always_comb begin
    accept    = (state == IDLE) && bus.start;
    zero_div  = (bus.divisor == '0);
    last_iter = (count == CW'(WIDTH - 1));
    shifted   = {prem, mag_d[WIDTH-1]};
    trial     = shifted - {2'b00, mag_v};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !zero_div) state_next = RUN;
      RUN:     if (last_iter) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = (state != IDLE);
    bus.done        = done_r;
    bus.quotient    = quotient_r;
    bus.remainder   = remainder_r;
    bus.div_by_zero = dbz_r;
  end

  // A zero divisor bypasses RUN and reports straight from IDLE on the start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count       <= '0;
      mag_d       <= '0;
      mag_v       <= '0;
      prem        <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (zero_div) begin
              quotient_r  <= '1;
              remainder_r <= bus.dividend;
              dbz_r       <= 1'b1;
              done_r      <= 1'b1;
            end else begin
              sign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
              sign_r <= bus.dividend[WIDTH-1];
              mag_d  <= bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
              mag_v  <= bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
              prem   <= '0;
              count  <= '0;
            end
          end
        end
        RUN: begin
          prem  <= trial[WIDTH+1] ? shifted[WIDTH:0] : trial[WIDTH:0];
          mag_d <= {mag_d[WIDTH-2:0], ~trial[WIDTH+1]};
          count <= count + 1'b1;
        end
        FIX: begin
          quotient_r  <= sign_q ? -mag_d : mag_d;
          remainder_r <= sign_r ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
          dbz_r       <= 1'b0;
          done_r      <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_divider_seq.sv
// Self-checking bench for booth_divider_seq: directed sign/boundary cases plus
// randomized operands against an arithmetic reference with cycle-level timing.
module tb_booth_divider_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  booth_divider_seq_if #(.WIDTH(W)) bus ();

  booth_divider_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  bit checking = 1'b0;

  bit             model_busy = 1'b0;
  int             edge_no = 0;
  int             done_edge = 0;
  logic [W-1:0]   exp_q = '0, exp_r = '0, pend_q = '0, pend_r = '0;
  logic           exp_z = 1'b0, exp_done = 1'b0;

  // Reference result packed as {div_by_zero, quotient, remainder}.
  function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    int ai, bi, q, r;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) return {1'b1, {W{1'b1}}, a};
    q = ai / bi;
    r = ai % bi;
    return {1'b0, q[W-1:0], r[W-1:0]};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: results appear WIDTH+1 edges after an accepted start.
  always @(posedge clk) begin
    logic [2*W:0] res;
    edge_no++;
    if (!rst_n) begin
      model_busy = 1'b0;
      exp_q = '0; exp_r = '0; exp_z = 1'b0; exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (model_busy) begin
        if (edge_no == done_edge) begin
          exp_q = pend_q; exp_r = pend_r; exp_z = 1'b0; exp_done = 1'b1;
          model_busy = 1'b0;
        end
      end else if (bus.start) begin
        res = ref_div(bus.dividend, bus.divisor);
        if (res[2*W]) begin
          exp_q = res[2*W-1:W]; exp_r = res[W-1:0]; exp_z = 1'b1; exp_done = 1'b1;
        end else begin
          pend_q = res[2*W-1:W]; pend_r = res[W-1:0];
          model_busy = 1'b1;
          done_edge = edge_no + W + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      cmp("busy", 32'(bus.busy), 32'(model_busy));
      cmp("done", 32'(bus.done), 32'(exp_done));
      cmp("quotient", 32'(bus.quotient), 32'(exp_q));
      cmp("remainder", 32'(bus.remainder), 32'(exp_r));
      cmp("div_by_zero", 32'(bus.div_by_zero), 32'(exp_z));
    end
  end

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    bus.start = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor = W'($urandom);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (bus.done !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL done_timeout: got no done, expected done within 40 cycles at %0t", $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] q, input logic [W-1:0] r,
                             input logic z);
    cmp({name, "_q"}, 32'(bus.quotient), 32'(q));
    cmp({name, "_r"}, 32'(bus.remainder), 32'(r));
    cmp({name, "_dbz"}, 32'(bus.div_by_zero), 32'(z));
  endtask

  task automatic runCase(input string name, input int a, input int b, input int q, input int r);
    int lat;
    applyStimulus(W'(a), W'(b), lat);
    if (b == 0) cmp({name, "_lat"}, 32'(lat), 32'd1);
    else        cmp({name, "_lat"}, 32'(lat - 1), 32'(W + 1));
    checkOutput(name, W'(q), W'(r), b == 0);
  endtask

  int da[11] = '{100, -100, 100, -100, 0, -128, -128, 127, -128, 5, 9};
  int db[11] = '{7, 7, -7, -7, 5, -1, 1, -128, 3, 0, 3};
  int dq[11] = '{14, -14, -14, 14, 0, -128, -128, 0, -42, -1, 3};
  int dr[11] = '{2, -2, 2, -2, 0, 0, 0, 127, -2, 5, 0};

  initial begin
    logic [2*W:0] res;
    int lat, n_done;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;

    res = ref_div(8'd100, 8'd7);
    cmp("model_100_7", 32'(res), 32'({1'b0, 8'd14, 8'd2}));
    res = ref_div(8'h80, 8'hFF);
    cmp("model_m128_m1", 32'(res), 32'({1'b0, 8'h80, 8'h00}));
    res = ref_div(8'd5, 8'd0);
    cmp("model_5_0", 32'(res), 32'({1'b1, 8'hFF, 8'd5}));

    @(posedge clk);
    @(negedge clk);
    checking = 1'b1;
    checkOutput("reset", '0, '0, 1'b0);
    cmp("reset_busy", 32'(bus.busy), 32'd0);
    cmp("reset_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      runCase($sformatf("dir%0d", i), da[i], db[i], dq[i], dr[i]);
      @(negedge clk);
    end

    // Restart pulsed mid-operation must be ignored.
    bus.start = 1'b1; bus.dividend = W'(100); bus.divisor = W'(7);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.dividend = W'(50); bus.divisor = W'(5);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("ignore_restart", W'(14), W'(2), 1'b0);
    @(negedge clk);
    cmp("single_done", 32'(bus.done), 32'd0);

    // Abort with reset during iteration 4.
    bus.start = 1'b1; bus.dividend = W'(100); bus.divisor = W'(7);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort", '0, '0, 1'b0);
    cmp("abort_busy", 32'(bus.busy), 32'd0);
    n_done = 0;
    repeat (14) begin
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
    end
    cmp("abort_no_done", 32'(n_done), 32'd0);
    runCase("after_abort", 81, 9, 9, 0);

    for (int i = 0; i < 1500; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
      applyStimulus(a, b, lat);
      if (b == '0) cmp("rand_lat_dbz", 32'(lat), 32'd1);
      else         cmp("rand_lat", 32'(lat - 1), 32'(W + 1));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    @(negedge clk);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
